ysyx_22050710_bpu: RTL and testbench

Branch prediction and resolution unit for the NPC core; successor to the single-cycle ID-stage branch unit. Performs an IF-stage lookup of a direct-mapped branch target buffer (BTB) with 2-bit saturating counters (BHT). Resolves the branch/jump/trap in ID, trains the tables, and issues a registered one-cycle redirect on mispredict. Depth and widths are parametrised.

---
 rtl/ysyx_22050710_bpu.sv | 202 ++++++++++++++++++++
 tb/tb_ysyx_22050710_bpu.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050710_bpu.sv
// ysyx_22050710_bpu: IF-stage BTB/BHT lookup plus ID-stage branch resolution.
// Direct-mapped BTB with 2-bit saturating counters, trained by the resolving
// ID instruction; mispredicts and traps produce a registered one-cycle redirect.
// Optional build macro: YSYX_22050710_BPU_STAT_EN adds o_stat_br / o_stat_miss.
module ysyx_22050710_bpu #(
   parameter int WORD_WD = 64,
   parameter int PC_WD   = 64,
   parameter int GPR_WD  = 64,
   parameter int IMM_WD  = 64,
   parameter int ENTRIES = 16
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [PC_WD-1:0]  i_if_pc,
   output logic              o_pred_taken,
   output logic [PC_WD-1:0]  o_pred_target,
   input  logic              i_valid,
   input  logic [PC_WD-1:0]  i_pc,
   input  logic [GPR_WD-1:0] i_rs1data,
   input  logic [GPR_WD-1:0] i_rs2data,
   input  logic [IMM_WD-1:0] i_imm,
   input  logic              i_bren,
   input  logic [2:0]        i_brfunc,
   input  logic              i_ep_sel,
   input  logic [PC_WD-1:0]  i_epnpc,
   input  logic              i_pred_taken,
   input  logic [PC_WD-1:0]  i_pred_target,
   output logic              o_redirect,
   output logic [PC_WD-1:0]  o_redirect_pc
`ifdef YSYX_22050710_BPU_STAT_EN
   ,
   output logic [31:0]       o_stat_br,
   output logic [31:0]       o_stat_miss
`endif
);

   localparam int IDX_WD = $clog2(ENTRIES);
   localparam int TAG_WD = PC_WD - IDX_WD - 2;

   typedef enum logic [2:0] {
      F_JAL  = 3'b000,
      F_JALR = 3'b001,
      F_BEQ  = 3'b010,
      F_BNE  = 3'b011,
      F_BLT  = 3'b100,
      F_BGE  = 3'b101,
      F_BLTU = 3'b110,
      F_BGEU = 3'b111
   } brfunc_e;

   // Table storage
   logic [ENTRIES-1:0] valid_q;
   logic [TAG_WD-1:0]  tag_q [ENTRIES];
   logic [PC_WD-1:0]   tgt_q [ENTRIES];
   logic [1:0]         ctr_q [ENTRIES];

   // Redirect register
   logic               redirect_q, redirect_d;
   logic [PC_WD-1:0]   redirect_pc_q, redirect_pc_d;

   // IF lookup
   logic [IDX_WD-1:0]  if_idx;
   logic [TAG_WD-1:0]  if_tag;
   logic               if_hit;

   // ID resolve / train
   brfunc_e            func;
   logic [WORD_WD-1:0] rs1w, rs2w;
   logic               eq, lt, ltu;
   logic [PC_WD-1:0]   pc_imm, rs1_imm, act_tgt;
   logic               act_taken, is_jump, mispredict, br_res;
   logic [IDX_WD-1:0]  id_idx;
   logic [TAG_WD-1:0]  id_tag;
   logic               id_hit;
   logic               wr_entry, wr_ctr;
   logic [1:0]         ctr_new;

   // Low PC bits never participate in indexing.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{i_if_pc[1:0]};

   // Combinational BTB/BHT lookup for the fetch PC (no write bypass).
   always_comb begin
      if_idx        = i_if_pc[IDX_WD+1:2];
      if_tag        = i_if_pc[PC_WD-1:IDX_WD+2];
      if_hit        = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
      o_pred_taken  = if_hit && ctr_q[if_idx][1];
      o_pred_target = if_hit ? tgt_q[if_idx] : '0;
   end

   // Resolve the ID instruction: actual direction, target and mispredict.
   always_comb begin
      func    = brfunc_e'(i_brfunc);
      rs1w    = WORD_WD'(i_rs1data);
      rs2w    = WORD_WD'(i_rs2data);
      eq      = (rs1w == rs2w);
      lt      = ($signed(rs1w) < $signed(rs2w));
      ltu     = (rs1w < rs2w);
      pc_imm  = i_pc + PC_WD'(i_imm);
      rs1_imm = PC_WD'(i_rs1data) + PC_WD'(i_imm);
      act_tgt = pc_imm;
      act_taken = 1'b0;
      case (func)
         F_JAL:  act_taken = 1'b1;
         F_JALR: begin
            act_taken = 1'b1;
            act_tgt   = {rs1_imm[PC_WD-1:1], 1'b0};
         end
         F_BEQ:  act_taken = eq;
         F_BNE:  act_taken = !eq;
         F_BLT:  act_taken = lt;
         F_BGE:  act_taken = !lt;
         F_BLTU: act_taken = ltu;
         F_BGEU: act_taken = !ltu;
         default: act_taken = 1'b0;
      endcase
      is_jump    = (func == F_JAL) || (func == F_JALR);
      mispredict = (act_taken != i_pred_taken) ||
                   (act_taken && (act_tgt != i_pred_target));
      br_res     = i_valid && i_bren && !i_ep_sel;
      redirect_d = i_valid && (i_ep_sel || (i_bren && mispredict));
      if (i_ep_sel)
         redirect_pc_d = i_epnpc;
      else if (act_taken)
         redirect_pc_d = act_tgt;
      else
         redirect_pc_d = i_pc + PC_WD'(4);
   end

   // Training decisions for the resolving instruction's table entry.
   always_comb begin
      id_idx   = i_pc[IDX_WD+1:2];
      id_tag   = i_pc[PC_WD-1:IDX_WD+2];
      id_hit   = valid_q[id_idx] && (tag_q[id_idx] == id_tag);
      wr_entry = br_res && act_taken;
      wr_ctr   = br_res && (is_jump || id_hit || act_taken);
      if (is_jump)
         ctr_new = 2'b11;
      else if (!id_hit)
         ctr_new = 2'b10;
      else if (act_taken)
         ctr_new = (ctr_q[id_idx] == 2'b11) ? 2'b11 : ctr_q[id_idx] + 2'd1;
      else
         ctr_new = (ctr_q[id_idx] == 2'b00) ? 2'b00 : ctr_q[id_idx] - 2'd1;
   end

   // Table write port; reset clears valid bits and sets counters weakly not-taken.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         valid_q <= '0;
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            tag_q[i] <= '0;
            tgt_q[i] <= '0;
            ctr_q[i] <= 2'b01;
         end
      end else begin
         if (wr_entry) begin
            valid_q[id_idx] <= 1'b1;
            tag_q[id_idx]   <= id_tag;
            tgt_q[id_idx]   <= act_tgt;
         end
         if (wr_ctr)
            ctr_q[id_idx] <= ctr_new;
      end
   end

   // Registered redirect pulse; the PC holds its last value between redirects.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
      end else begin
         redirect_q <= redirect_d;
         if (redirect_d)
            redirect_pc_q <= redirect_pc_d;
      end
   end

   assign o_redirect    = redirect_q;
   assign o_redirect_pc = redirect_pc_q;

`ifdef YSYX_22050710_BPU_STAT_EN
   logic [31:0] stat_br_q, stat_miss_q;

   // Event counters: resolved branches/jumps and non-trap redirects.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         stat_br_q   <= '0;
         stat_miss_q <= '0;
      end else begin
         if (i_valid && i_bren)
            stat_br_q <= stat_br_q + 32'd1;
         if (br_res && mispredict)
            stat_miss_q <= stat_miss_q + 32'd1;
      end
   end

   assign o_stat_br   = stat_br_q;
   assign o_stat_miss = stat_miss_q;
`endif

endmodule

// File: tb/tb_ysyx_22050710_bpu.sv
// Self-checking bench for ysyx_22050710_bpu: directed vectors, a per-cycle
// comparison against a table-level model, and hand-computed literal checks.
module tb_ysyx_22050710_bpu;

   localparam int N = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] if_pc;
   logic        pred_taken_o;
   logic [63:0] pred_target_o;
   logic        valid;
   logic [63:0] pc, rs1, rs2, imm;
   logic        bren;
   logic [2:0]  brfunc;
   logic        ep_sel;
   logic [63:0] epnpc;
   logic        pt;
   logic [63:0] ptg;
   logic        redirect_o;
   logic [63:0] redirect_pc_o;

   int ntests = 0;
   int nfail  = 0;

   always #5 clk = ~clk;

   ysyx_22050710_bpu #(
      .WORD_WD(64), .PC_WD(64), .GPR_WD(64), .IMM_WD(64), .ENTRIES(N)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_if_pc(if_pc),
      .o_pred_taken(pred_taken_o), .o_pred_target(pred_target_o),
      .i_valid(valid), .i_pc(pc), .i_rs1data(rs1), .i_rs2data(rs2),
      .i_imm(imm), .i_bren(bren), .i_brfunc(brfunc), .i_ep_sel(ep_sel),
      .i_epnpc(epnpc), .i_pred_taken(pt), .i_pred_target(ptg),
      .o_redirect(redirect_o), .o_redirect_pc(redirect_pc_o)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- model: table of entries, pure arithmetic on PCs --------
   bit          m_valid [N];
   logic [63:0] m_tag   [N];
   logic [63:0] m_tgt   [N];
   int          m_ctr   [N];
   bit          exp_redir;
   logic [63:0] exp_rpc;

   function automatic int idx_of(input logic [63:0] a);
      return int'((a / 64'd4) % 64'(N));
   endfunction

   function automatic logic [63:0] tag_of(input logic [63:0] a);
      return a / (64'd4 * 64'(N));
   endfunction

   always @(posedge clk or negedge rst_n) begin : mdl
      int k;
      bit tk, hit;
      logic [63:0] tg;
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            m_valid[i] = 0; m_ctr[i] = 1; m_tag[i] = 0; m_tgt[i] = 0;
         end
         exp_redir = 0;
         exp_rpc   = 0;
      end else begin
         exp_redir = 0;
         if (valid && ep_sel) begin
            exp_redir = 1;
            exp_rpc   = epnpc;
         end else if (valid && bren) begin
            tg = pc + imm;
            case (brfunc)
               3'd0: tk = 1;
               3'd1: begin tk = 1; tg = (rs1 + imm) & ~64'd1; end
               3'd2: tk = (rs1 == rs2);
               3'd3: tk = (rs1 != rs2);
               3'd4: tk = ($signed(rs1) < $signed(rs2));
               3'd5: tk = ($signed(rs1) >= $signed(rs2));
               3'd6: tk = (rs1 < rs2);
               default: tk = (rs1 >= rs2);
            endcase
            if ((tk != pt) || (tk && tg != ptg)) begin
               exp_redir = 1;
               exp_rpc   = tk ? tg : pc + 64'd4;
            end
            k   = idx_of(pc);
            hit = m_valid[k] && (m_tag[k] == tag_of(pc));
            if (brfunc <= 3'd1) m_ctr[k] = 3;
            else if (hit)       m_ctr[k] = tk ? ((m_ctr[k] < 3) ? m_ctr[k] + 1 : 3)
                                              : ((m_ctr[k] > 0) ? m_ctr[k] - 1 : 0);
            else if (tk)        m_ctr[k] = 2;
            if (tk) begin
               m_valid[k] = 1; m_tag[k] = tag_of(pc); m_tgt[k] = tg;
            end
         end
      end
   end

   // Compare process: outputs checked against the model every falling edge.
   always @(negedge clk) begin : cmp
      int k;
      bit hit;
      if (rst_n) begin
         k   = idx_of(if_pc);
         hit = m_valid[k] && (m_tag[k] == tag_of(if_pc));
         chk("cyc_pred_taken", {63'd0, pred_taken_o}, {63'd0, hit && (m_ctr[k] >= 2)});
         chk("cyc_pred_target", pred_target_o, hit ? m_tgt[k] : 64'd0);
         chk("cyc_redirect", {63'd0, redirect_o}, {63'd0, exp_redir});
         if (exp_redir) chk("cyc_redirect_pc", redirect_pc_o, exp_rpc);
      end else begin
         chk("cyc_redirect_in_reset", {63'd0, redirect_o}, 64'd0);
      end
   end

   // One ID cycle: drive the instruction (also looked up by IF) and step an edge.
   task automatic cyc(input logic v, input logic [63:0] p, input logic [63:0] a,
                      input logic [63:0] b, input logic [63:0] im, input logic br,
                      input logic [2:0] f, input logic ptk, input logic [63:0] ptt);
      valid = v; pc = p; if_pc = p; rs1 = a; rs2 = b; imm = im;
      bren = br; brfunc = f; pt = ptk; ptg = ptt;
      @(posedge clk); #1;
   endtask

   task automatic look(input logic [63:0] a);
      if_pc = a; #1;
   endtask

   initial begin
      rst_n = 0; if_pc = 64'h8000_0000; valid = 0; pc = 0; rs1 = 0; rs2 = 0;
      imm = 0; bren = 0; brfunc = 0; ep_sel = 0; epnpc = 0; pt = 0; ptg = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_redirect", {63'd0, redirect_o}, 64'd0);
      chk("rst_redirect_pc", redirect_pc_o, 64'd0);
      chk("rst_pred_taken", {63'd0, pred_taken_o}, 64'd0);
      rst_n = 1;

      // beq taken, predicted not-taken -> redirect, allocate counter 10
      cyc(1, 64'h8000_0000, 5, 5, 64'h10, 1, 3'd2, 0, 0);
      chk("beq1_redirect", {63'd0, redirect_o}, 64'd1);
      chk("beq1_redirect_pc", redirect_pc_o, 64'h8000_0010);
      chk("beq1_lookup_taken", {63'd0, pred_taken_o}, 64'd1);
      chk("beq1_lookup_target", pred_target_o, 64'h8000_0010);
      // correctly predicted -> no redirect, counter 11
      cyc(1, 64'h8000_0000, 5, 5, 64'h10, 1, 3'd2, 1, 64'h8000_0010);
      chk("beq2_no_redirect", {63'd0, redirect_o}, 64'd0);
      // not taken twice: 11 -> 10 (still taken) -> 01 (not taken)
      cyc(1, 64'h8000_0000, 5, 6, 64'h10, 1, 3'd2, 1, 64'h8000_0010);
      chk("beq3_redirect_pc", redirect_pc_o, 64'h8000_0004);
      chk("beq3_still_taken", {63'd0, pred_taken_o}, 64'd1);
      cyc(1, 64'h8000_0000, 5, 6, 64'h10, 1, 3'd2, 1, 64'h8000_0010);
      chk("beq4_flipped", {63'd0, pred_taken_o}, 64'd0);

      // signed vs unsigned compares
      cyc(1, 64'h8000_0104, '1, 1, 64'h20, 1, 3'd4, 0, 0);
      chk("blt_redirect_pc", redirect_pc_o, 64'h8000_0124);
      cyc(1, 64'h8000_0108, '1, 1, 64'h20, 1, 3'd6, 0, 0);
      chk("bltu_no_redirect", {63'd0, redirect_o}, 64'd0);
      chk("bltu_no_alloc", {63'd0, pred_taken_o}, 64'd0);
      cyc(1, 64'h8000_010c, 0, 0, 64'h8, 1, 3'd7, 0, 0);
      chk("bgeu_redirect_pc", redirect_pc_o, 64'h8000_0114);

      // jalr clears bit 0 and installs a strongly-taken entry
      cyc(1, 64'h8000_0110, 64'h8000_1001, 0, 64'h2, 1, 3'd1, 0, 0);
      chk("jalr_redirect_pc", redirect_pc_o, 64'h8000_1002);
      chk("jalr_lookup_target", pred_target_o, 64'h8000_1002);

      // jal: right target, then wrong target, then back-to-back bne mispredict
      cyc(1, 64'h8000_0120, 0, 0, 64'hFFFF_FFFF_FFFF_FFF8, 1, 3'd0, 1, 64'h8000_0118);
      chk("jal_no_redirect", {63'd0, redirect_o}, 64'd0);
      cyc(1, 64'h8000_0120, 0, 0, 64'hFFFF_FFFF_FFFF_FFF8, 1, 3'd0, 1, 64'h8000_0000);
      chk("jal_bad_tgt_pc", redirect_pc_o, 64'h8000_0118);
      cyc(1, 64'h8000_0124, 1, 2, 64'h40, 1, 3'd3, 0, 0);
      chk("bne_b2b_redirect", {63'd0, redirect_o}, 64'd1);
      chk("bne_b2b_pc", redirect_pc_o, 64'h8000_0164);

      // invalid / non-branch: nothing happens
      cyc(0, 64'h8000_0128, 1, 2, 64'h8, 1, 3'd3, 0, 0);
      chk("invalid_no_redirect", {63'd0, redirect_o}, 64'd0);
      cyc(1, 64'h8000_0128, 1, 2, 64'h8, 0, 3'd3, 0, 0);
      chk("nobr_no_redirect", {63'd0, redirect_o}, 64'd0);
      chk("nobr_no_write", {63'd0, pred_taken_o}, 64'd0);

      // trap redirect, no table write
      ep_sel = 1; epnpc = 64'h8000_0100;
      cyc(1, 64'h8000_0140, 5, 5, 64'h8, 1, 3'd2, 0, 0);
      ep_sel = 0;
      chk("ep_redirect", {63'd0, redirect_o}, 64'd1);
      chk("ep_redirect_pc", redirect_pc_o, 64'h8000_0100);
      chk("ep_no_write", {63'd0, pred_taken_o}, 64'd0);

      // aliasing on index 0
      look(64'h8000_0040);
      chk("alias_miss_taken", {63'd0, pred_taken_o}, 64'd0);
      chk("alias_miss_target", pred_target_o, 64'd0);
      cyc(1, 64'h8000_0040, 3, 3, 64'h40, 1, 3'd2, 0, 0);
      chk("alias_alloc_target", pred_target_o, 64'h8000_0080);
      look(64'h8000_0000);
      chk("alias_evicted", {63'd0, pred_taken_o}, 64'd0);

      // saturation: four taken with fed-back prediction, then two not-taken
      for (int i = 0; i < 4; i++) begin
         look(64'h8000_0118);
         cyc(1, 64'h8000_0118, 7, 7, 64'h10, 1, 3'd2, pred_taken_o, pred_target_o);
      end
      cyc(1, 64'h8000_0118, 7, 8, 64'h10, 1, 3'd2, 1, 64'h8000_0128);
      chk("sat_one_down", {63'd0, pred_taken_o}, 64'd1);
      cyc(1, 64'h8000_0118, 7, 8, 64'h10, 1, 3'd2, 1, 64'h8000_0128);
      chk("sat_two_down", {63'd0, pred_taken_o}, 64'd0);

      // trap in the same cycle as async reset: discarded, table cleared
      valid = 1; bren = 1; ep_sel = 1; epnpc = 64'h8000_0100; if_pc = 64'h8000_0040;
      rst_n = 0;
      @(posedge clk); #1;
      chk("rst_ep_no_redirect", {63'd0, redirect_o}, 64'd0);
      chk("rst_table_cleared", {63'd0, pred_taken_o}, 64'd0);
      rst_n = 1; ep_sel = 0;
      cyc(0, 64'h8000_0040, 0, 0, 0, 0, 3'd0, 0, 0);
      chk("post_rst_no_redirect", {63'd0, redirect_o}, 64'd0);
      chk("post_rst_miss", {63'd0, pred_taken_o}, 64'd0);
      @(posedge clk); #1;

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
